// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank: operating-mode encodings.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_MODE = 2'b00,
        CNT_UP  = 2'b01,
        CNT_DN  = 2'b10,
        LOAD    = 2'b11
    } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous reset to rst_val and a clock enable.
// q and qbar are separate flops kept in lockstep.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_d;

    // Next state from the four JK cases.
    always_comb begin
        q_d = q;
        unique case ({j, k})
            2'b00: q_d = q;
            2'b01: q_d = 1'b0;
            2'b10: q_d = 1'b1;
            2'b11: q_d = ~q;
            default: q_d = q;
        endcase
    end

    // State flops; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= rst_val;
            qbar <= ~rst_val;
        end else if (en) begin
            q    <= q_d;
            qbar <= ~q_d;
        end
    end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK cells with per-bit JK, direct load and up/down counting.
// Counting chains the cells as toggle stages; no adder is used.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             wrap
);

    jk_mode_t         mode_sel;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             wrap_d;

    assign mode_sel = jk_mode_t'(mode);

    // Toggle chains: a stage toggles when all lower stages are 1 (up) or 0 (down).
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & qbar[i-1];
        end
    end

    // Mode mux selecting the J/K drive of every cell.
    always_comb begin
        cell_j = '0;
        cell_k = '0;
        unique case (mode_sel)
            JK_MODE: begin
                cell_j = j;
                cell_k = k;
            end
            CNT_UP: begin
                cell_j = t_up;
                cell_k = t_up;
            end
            CNT_DN: begin
                cell_j = t_dn;
                cell_k = t_dn;
            end
            LOAD: begin
                cell_j = j;
                cell_k = ~j;
            end
            default: begin
                cell_j = '0;
                cell_k = '0;
            end
        endcase
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .rst_val (RST_VAL[g]),
            .j       (cell_j[g]),
            .k       (cell_k[g]),
            .q       (q[g]),
            .qbar    (qbar[g])
        );
    end

    // Wrap occurs when the whole toggle chain carries out of the top cell.
    always_comb begin
        wrap_d = 1'b0;
        if (en) begin
            if (mode_sel == CNT_UP) wrap_d = &q;
            else if (mode_sel == CNT_DN) wrap_d = &qbar;
        end
    end

    // One-cycle wrap pulse register.
    always_ff @(posedge clk) begin
        if (rst) wrap <= 1'b0;
        else     wrap <= wrap_d;
    end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised bank of WIDTH JK flip-flops sharing one clock, synchronous reset and clock enable. It extends the single-bit JK flip-flop with per-bit J/K control, a direct-load mode, and a synchronous up/down counter mode in which the cells are chained as toggle stages. It is the general-purpose state-holding primitive for control registers, event latches and small counters in the design.

## Interface
- WIDTH, default 8: number of JK cells (≥1).
- RST_VAL, default 0: WIDTH-bit value loaded into q on reset.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0 all state holds, regardless of mode.
- mode  input  2  operating mode: 00 JK, 01 COUNT_UP, 10 COUNT_DOWN, 11 LOAD.
- j  input  WIDTH  per-bit J in JK mode; load data in LOAD mode.
- k  input  WIDTH  per-bit K in JK mode; ignored in all other modes.
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  always exactly ~q, in every cycle including reset.
- wrap  output  1  registered one-cycle pulse: counter wrapped on the previous edge.

## Operation
- Reset (rst=1 at an edge): q←RST_VAL, qbar←~RST_VAL, wrap←0. Reset overrides en and mode.
- en=0, rst=0: q and qbar hold; wrap←0.
- JK mode, per bit i: J=0,K=0 hold; J=0,K=1 q[i]←0; J=1,K=0 q[i]←1; J=1,K=1 q[i]←~q[i]. wrap←0.
- COUNT_UP: each cell is driven as T, J=K=T, with T[0]=1 and T[i]=&q[i-1:0]. Result q←q+1 mod 2^WIDTH. wrap←1 iff q was all ones before the edge.
- COUNT_DOWN: T[0]=1 and T[i]=&qbar[i-1:0]. Result q←q−1 mod 2^WIDTH. wrap←1 iff q was all zeros before the edge.
- LOAD: q←j; wrap←0.
- The toggle chains must be built from per-cell J/K and T signals. Do not use a behavioural adder; the test bench checks the arithmetic result only.
- A mode change takes effect at the next enabled edge. There is no pipeline state and no settling cycle.
- qbar is its own register, updated in lockstep with q; it is never derived through an inverter after the flop.

## Timing
- All outputs are registered. Latency from inputs to q, qbar and wrap is one clk edge.
- wrap is high for exactly one cycle, in the cycle after the wrapping edge. Consecutive wraps are possible when WIDTH=1: in COUNT_UP, wrap is high every other cycle.
- If rst is asserted mid-count, the next edge gives q=RST_VAL and wrap=0, even when that edge would have wrapped.
- If en drops for N cycles during counting, the count resumes unchanged when en returns. wrap is 0 during the hold.
- There are no combinational paths from inputs to outputs.

## Structure
- The shared package jk_pkg holds the mode encodings as the typedef jk_mode_t: JK_MODE=2'b00, CNT_UP=2'b01, CNT_DN=2'b10, LOAD=2'b11.
- Sub-module jk_cell provides one bit: clk, rst, en, rst_val, j, k, q, qbar. It has the four-case JK behaviour, a synchronous reset to rst_val, and an enable.
- jk_reg_bank instantiates WIDTH jk_cell instances in a generate loop. A mode mux in front of the cells selects per-bit J/K from the external j/k, the T chains, or load (J=d, K=~d).
- The wrap flop sits in jk_reg_bank.

## Test plan
- Reset: WIDTH=8, RST_VAL=8'hA5, rst=1 for one edge → q=8'hA5, qbar=8'h5A, wrap=0. Hold rst for 3 edges with en=1 and mode=CNT_UP → q stays 8'hA5.
- JK per-bit: start at q=8'h0F. Apply j=8'hF0, k=8'h0C → q=8'hF3. Then j=k=8'hFF → q=8'h0C. Then j=k=0 for 2 edges → q=8'h0C.
- Count up and wrap: LOAD j=8'hFE, then CNT_UP → q=8'hFF, then 8'h00 with wrap=1 on the following cycle only, then 8'h01 with wrap=0.
- Count down and wrap: LOAD 8'h01, then CNT_DN → q=8'h00, then 8'hFF with wrap=1 for one cycle. Drop en for 3 cycles → q=8'hFF held, wrap=0.
- Reset mid-operation: q=8'hFF in CNT_UP, assert rst at the wrapping edge → q=RST_VAL, wrap=0 on the next cycle.
- Every cycle of every test: qbar==~q. A WIDTH=1 build in CNT_UP gives the q sequence 0,1,0,1, with wrap high on alternate cycles.
